// File: rtl/inst_fetch.sv
// ============================================================================
//  Module      : inst_fetch
//  Description : MIPS 5-stage pipeline instruction-fetch stage. Owns the PC,
//                talks to instruction memory over a req/ack handshake, keeps
//                a 1-entry skid buffer for stalls and drives the IF/ID
//                pipeline register.
//                Optional macro IF_PERF_CNT_EN adds fetch/stall/flush
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_inst,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc_next
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
`endif
);

  localparam logic [31:0] c_PC_RESET  = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] c_PC_STEP   = 32'd4;
  localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

  // FETCH: request for r_pc outstanding; HOLD: skid full, no request;
  // DROP: stale request outstanding, its data will be discarded.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_drop_addr_nxt;
  logic [31:0] w_skid_inst_nxt;
  logic [31:0] w_skid_pc_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_inst_nxt;
  logic [31:0] w_if_pc_nxt;
  logic        w_if_load;
  logic [31:0] w_pc_inc;

  assign w_pc_inc = r_pc + c_PC_STEP;

  // State register; frozen while the CPU is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else if (i_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decisions: redirect > stall > normal.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_addr_nxt = r_drop_addr;
    w_skid_inst_nxt = r_skid_inst;
    w_skid_pc_nxt   = r_skid_pc;
    w_if_valid_nxt  = r_if_valid;
    w_if_inst_nxt   = r_if_inst;
    w_if_pc_nxt     = r_if_pc;
    w_if_load       = 1'b0;

    if (i_redirect_valid) begin
      w_pc_nxt       = i_redirect_pc & c_WORD_MASK;
      w_if_valid_nxt = 1'b0;
      w_if_inst_nxt  = 32'h0000_0000;
      if ((r_state != S_HOLD) && !i_imem_ack) begin
        // The in-flight request must still complete; remember its address
        // so the handshake stays stable, then throw its data away.
        w_state_nxt = S_DROP;
        if (r_state == S_FETCH) begin
          w_drop_addr_nxt = r_pc;
        end
      end else begin
        w_state_nxt = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_imem_ack) begin
            w_pc_nxt = w_pc_inc;
            if (i_stall) begin
              w_skid_inst_nxt = i_imem_rdata;
              w_skid_pc_nxt   = r_pc;
              w_state_nxt     = S_HOLD;
            end else begin
              w_if_valid_nxt = 1'b1;
              w_if_inst_nxt  = i_imem_rdata;
              w_if_pc_nxt    = r_pc;
              w_if_load      = 1'b1;
            end
          end else if (!i_stall) begin
            w_if_valid_nxt = 1'b0;
            w_if_inst_nxt  = 32'h0000_0000;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = r_skid_inst;
            w_if_pc_nxt    = r_skid_pc;
            w_if_load      = 1'b1;
            w_state_nxt    = S_FETCH;
          end
        end
        S_DROP: begin
          if (i_imem_ack) begin
            w_state_nxt = S_FETCH;
          end
          if (!i_stall) begin
            w_if_valid_nxt = 1'b0;
            w_if_inst_nxt  = 32'h0000_0000;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  // PC, skid buffer and IF/ID register; frozen while the CPU is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= c_PC_RESET;
      r_drop_addr <= 32'h0000_0000;
      r_skid_inst <= 32'h0000_0000;
      r_skid_pc   <= 32'h0000_0000;
      r_if_valid  <= 1'b0;
      r_if_inst   <= 32'h0000_0000;
      r_if_pc     <= 32'h0000_0000;
    end else if (i_en) begin
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
      r_skid_inst <= w_skid_inst_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_pc     <= w_if_pc_nxt;
    end
  end

  // Request is held off during reset and whenever the skid holds an
  // instruction; in DROP the stale address is kept on the bus.
  assign o_imem_req   = rst_n & (r_state != S_HOLD);
  assign o_imem_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign o_if_valid   = r_if_valid;
  assign o_if_inst    = r_if_inst;
  assign o_if_pc      = r_if_pc;
  assign o_if_pc_next = r_if_pc + c_PC_STEP;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Free-running wrapping event counters, advancing only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch_cnt <= 32'h0000_0000;
      r_perf_stall_cnt <= 32'h0000_0000;
      r_perf_flush_cnt <= 32'h0000_0000;
    end else if (i_en) begin
      if (w_if_load) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (i_stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (i_redirect_valid) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch_cnt;
  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch: directed vector table
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, rv, ack;
  logic [31:0] rpc, rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_inst, if_pc, if_pc_next;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_en            (en),
    .i_stall         (stall),
    .i_redirect_valid(rv),
    .i_redirect_pc   (rpc),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ack      (ack),
    .i_imem_rdata    (rdata),
    .o_if_valid      (if_valid),
    .o_if_inst       (if_inst),
    .o_if_pc         (if_pc),
    .o_if_pc_next    (if_pc_next)
`ifdef IF_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt(perf_fetch),
    .o_perf_stall_cnt(perf_stall),
    .o_perf_flush_cnt(perf_flush)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en, stall, rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] einst, epc;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic e, s, r, input logic [31:0] rp,
                              input logic a, input logic [31:0] rd,
                              input logic q, input logic [31:0] ad,
                              input logic v, input logic [31:0] ins, pc);
    vec_t t;
    t.en = e; t.stall = s; t.rv = r; t.rpc = rp; t.ack = a; t.rdata = rd;
    t.ereq = q; t.eaddr = ad; t.ev = v; t.einst = ins; t.epc = pc;
    return t;
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [31:0] inst, pc; } sk_t;
  sk_t         skid[$];
  logic [31:0] m_pc, m_pend_addr, m_inst, m_ifpc;
  logic        m_pend, m_stale, m_v;
  logic [31:0] m_fetch_cnt, m_stall_cnt, m_flush_cnt;

  task automatic model_reset();
    skid.delete();
    m_pc = 32'h0; m_pend = 1'b1; m_pend_addr = 32'h0; m_stale = 1'b0;
    m_v = 1'b0; m_inst = 32'h0; m_ifpc = 32'h0;
    m_fetch_cnt = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic model_step(input logic e, s, r, input logic [31:0] rp,
                            input logic a, input logic [31:0] rd);
    logic got;
    sk_t  sk;
    if (!e) return;
    if (s) m_stall_cnt++;
    if (r) begin
      m_flush_cnt++;
      m_stale = m_pend && !a;          // in-flight request becomes junk
      m_pc = rp & 32'hFFFF_FFFC;
      m_v = 1'b0; m_inst = 32'h0;
      skid.delete();
      m_pend = 1'b1;
      if (!m_stale) m_pend_addr = m_pc;
    end else begin
      got = m_pend && a && !m_stale;
      if (m_pend && a && m_stale) begin
        m_stale = 1'b0; m_pend_addr = m_pc;
      end
      if (!s) begin
        if (skid.size() > 0) begin
          sk = skid.pop_front();
          m_v = 1'b1; m_inst = sk.inst; m_ifpc = sk.pc; m_fetch_cnt++;
          m_pend = 1'b1; m_pend_addr = m_pc;
        end else if (got) begin
          m_v = 1'b1; m_inst = rd; m_ifpc = m_pc; m_fetch_cnt++;
          m_pc = m_pc + 32'd4; m_pend_addr = m_pc;
        end else begin
          m_v = 1'b0; m_inst = 32'h0;
        end
      end else if (got) begin
        sk.inst = rd; sk.pc = m_pc;
        skid.push_back(sk);
        m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end
    end
  endtask

  initial begin
    // en stall rv rpc | ack rdata | req addr | valid inst pc
    tbl[0]  = mk(1,0,0,0,          1,32'hA000_0000, 1,32'h0,         1,32'hA000_0000,32'h0);
    tbl[1]  = mk(1,0,0,0,          1,32'hA000_0004, 1,32'h4,         1,32'hA000_0004,32'h4);
    tbl[2]  = mk(1,0,0,0,          1,32'hA000_0008, 1,32'h8,         1,32'hA000_0008,32'h8);
    tbl[3]  = mk(1,0,0,0,          1,32'hA000_000C, 1,32'hC,         1,32'hA000_000C,32'hC);
    tbl[4]  = mk(1,0,0,0,          0,32'h0,         1,32'h10,        0,32'h0,32'hC);
    tbl[5]  = mk(1,0,0,0,          0,32'h0,         1,32'h10,        0,32'h0,32'hC);
    tbl[6]  = mk(1,0,0,0,          1,32'hA000_0010, 1,32'h10,        1,32'hA000_0010,32'h10);
    tbl[7]  = mk(1,0,0,0,          0,32'h0,         1,32'h14,        0,32'h0,32'h10);
    tbl[8]  = mk(1,0,0,0,          1,32'hA000_0014, 1,32'h14,        1,32'hA000_0014,32'h14);
    tbl[9]  = mk(1,1,0,0,          1,32'hA000_0018, 1,32'h18,        1,32'hA000_0014,32'h14);
    tbl[10] = mk(1,1,0,0,          0,32'h0,         0,32'h0,         1,32'hA000_0014,32'h14);
    tbl[11] = mk(1,0,0,0,          0,32'h0,         0,32'h0,         1,32'hA000_0018,32'h18);
    tbl[12] = mk(1,0,0,0,          0,32'h0,         1,32'h1C,        0,32'h0,32'h18);
    tbl[13] = mk(1,0,1,32'h103,    0,32'h0,         1,32'h1C,        0,32'h0,32'h18);
    tbl[14] = mk(1,0,0,0,          0,32'h0,         1,32'h1C,        0,32'h0,32'h18);
    tbl[15] = mk(1,0,0,0,          1,32'hDEAD_BEEF, 1,32'h1C,        0,32'h0,32'h18);
    tbl[16] = mk(1,0,0,0,          1,32'hA000_0100, 1,32'h100,       1,32'hA000_0100,32'h100);
    tbl[17] = mk(1,1,1,32'hFFFF_FFF8, 1,32'h1234_5678, 1,32'h104,    0,32'h0,32'h100);
    tbl[18] = mk(1,1,0,0,          0,32'h0,         1,32'hFFFF_FFF8, 0,32'h0,32'h100);
    tbl[19] = mk(1,0,0,0,          1,32'hB000_0000, 1,32'hFFFF_FFF8, 1,32'hB000_0000,32'hFFFF_FFF8);
    tbl[20] = mk(1,0,0,0,          1,32'hB000_0001, 1,32'hFFFF_FFFC, 1,32'hB000_0001,32'hFFFF_FFFC);
    tbl[21] = mk(1,0,0,0,          1,32'hB000_0002, 1,32'h0,         1,32'hB000_0002,32'h0);
    tbl[22] = mk(1,1,0,0,          1,32'hB000_0003, 1,32'h4,         1,32'hB000_0002,32'h0);
    tbl[23] = mk(1,1,1,32'h40,     0,32'h0,         0,32'h0,         0,32'h0,32'h0);
    tbl[24] = mk(1,0,0,0,          1,32'hC000_0040, 1,32'h40,        1,32'hC000_0040,32'h40);
    tbl[25] = mk(1,0,1,32'h80,     0,32'h0,         1,32'h44,        0,32'h0,32'h40);
    tbl[26] = mk(1,0,1,32'h90,     0,32'h0,         1,32'h44,        0,32'h0,32'h40);
    tbl[27] = mk(1,0,0,0,          1,32'h0000_0BAD, 1,32'h44,        0,32'h0,32'h40);
    tbl[28] = mk(1,0,0,0,          1,32'hC000_0090, 1,32'h90,        1,32'hC000_0090,32'h90);
    tbl[29] = mk(1,0,0,0,          0,32'h0,         1,32'h94,        0,32'h0,32'h90);
    tbl[30] = mk(0,1,0,0,          0,32'h0,         1,32'h94,        0,32'h0,32'h90);
    tbl[31] = mk(0,0,1,32'h200,    0,32'h0,         1,32'h94,        0,32'h0,32'h90);
    tbl[32] = mk(0,0,0,0,          0,32'h0,         1,32'h94,        0,32'h0,32'h90);
    tbl[33] = mk(1,0,0,0,          1,32'hC000_0094, 1,32'h94,        1,32'hC000_0094,32'h94);
    tbl[34] = mk(0,0,0,0,          0,32'h0,         1,32'h98,        1,32'hC000_0094,32'h94);
    tbl[35] = mk(0,1,1,32'h300,    0,32'h0,         1,32'h98,        1,32'hC000_0094,32'h94);
    tbl[36] = mk(1,0,0,0,          0,32'h0,         1,32'h98,        0,32'h0,32'h94);

    rst_n = 1'b0; en = 1'b0; stall = 1'b0; rv = 1'b0; rpc = 32'h0; ack = 1'b0; rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req",     {31'h0, imem_req}, 32'h0);
    chk("reset_valid",   {31'h0, if_valid}, 32'h0);
    chk("reset_inst",    if_inst,           32'h0);
    chk("reset_pc",      if_pc,             32'h0);
    chk("reset_pc_next", if_pc_next,        32'h4);
    rst_n = 1'b1;

    // directed table: inputs at posedge+1, bus checked before the edge,
    // IF/ID checked after it
    for (int i = 0; i < NV; i++) begin
      en = tbl[i].en; stall = tbl[i].stall; rv = tbl[i].rv; rpc = tbl[i].rpc;
      ack = tbl[i].ack; rdata = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].eaddr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i),   {31'h0, if_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("vec%0d_inst", i),    if_inst,           tbl[i].einst);
      chk($sformatf("vec%0d_pc", i),      if_pc,             tbl[i].epc);
      chk($sformatf("vec%0d_pc_next", i), if_pc_next,        tbl[i].epc + 32'd4);
    end

    // asynchronous reset in mid-cycle: outputs must clear without an edge
    en = 1'b1; stall = 1'b0; rv = 1'b0; ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",     {31'h0, imem_req}, 32'h0);
    chk("async_rst_valid",   {31'h0, if_valid}, 32'h0);
    chk("async_rst_pc",      if_pc,             32'h0);
    chk("async_rst_pc_next", if_pc_next,        32'h4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      en    = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 3) == 0);
      rv    = ($urandom_range(0, 9) == 0);
      rpc   = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      ack   = en && m_pend && ($urandom_range(0, 2) != 0);
      rdata = $urandom;
      #1;
      chk("rnd_req", {31'h0, imem_req}, {31'h0, m_pend});
      if (m_pend) chk("rnd_addr", imem_addr, m_pend_addr);
      model_step(en, stall, rv, rpc, ack, rdata);
      @(posedge clk);
      #1;
      chk("rnd_valid",   {31'h0, if_valid}, {31'h0, m_v});
      chk("rnd_inst",    if_inst,           m_inst);
      chk("rnd_pc",      if_pc,             m_ifpc);
      chk("rnd_pc_next", if_pc_next,        m_ifpc + 32'd4);
    end

`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch, m_fetch_cnt);
    chk("perf_stall", perf_stall, m_stall_cnt);
    chk("perf_flush", perf_flush, m_flush_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
